// File: rtl/tlb_search_arbiter.sv
// Arbitrates the single TLB search port between CP0 TLBP, data and inst lookups.
// Define TLB_ARB_RR_EN for round-robin between data and inst (default: fixed priority).
module tlb_search_arbiter #(
   parameter int TLBNUM = 16,
   parameter int IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tlbp_req_i,
   input  logic            data_req_i,
   input  logic            inst_req_i,
   input  logic [18:0]     tlbp_vpn2_i,
   input  logic [18:0]     data_vpn2_i,
   input  logic [18:0]     inst_vpn2_i,
   input  logic            data_odd_i,
   input  logic            inst_odd_i,
   input  logic [7:0]      cp0_asid_i,
   input  logic            tlb_write_i,
   output logic            tlbp_gnt_o,
   output logic            data_gnt_o,
   output logic            inst_gnt_o,
   output logic            tlbp_rvalid_o,
   output logic            data_rvalid_o,
   output logic            inst_rvalid_o,
   output logic [18:0]     s_vpn2_o,
   output logic            s_odd_page_o,
   output logic [7:0]      s_asid_o,
   input  logic            s_found_i,
   input  logic [IDXW-1:0] s_index_i,
   input  logic [19:0]     s_pfn_i,
   input  logic [2:0]      s_c_i,
   input  logic            s_d_i,
   input  logic            s_v_i,
   output logic            r_found_o,
   output logic [IDXW-1:0] r_index_o,
   output logic [19:0]     r_pfn_o,
   output logic [2:0]      r_c_o,
   output logic            r_d_o,
   output logic            r_v_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_TLBP = 2'd0, OWN_DATA = 2'd1, OWN_INST = 2'd2} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic [18:0] vpn2_q;
   logic        odd_q;
   logic [7:0]  asid_q;
   logic        tlbpGnt, dataGnt, instGnt, anyGnt, canGrant, preferInst;

`ifdef TLB_ARB_RR_EN
   // Pointer set means inst is favoured next; only data/inst grants move it.
   logic rrPtr_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         rrPtr_q <= 1'b0;
      end else if (dataGnt) begin
         rrPtr_q <= 1'b1;
      end else if (instGnt) begin
         rrPtr_q <= 1'b0;
      end
   end
   assign preferInst = rrPtr_q;
`else
   assign preferInst = 1'b0;
`endif

   // Grant selection and next-state logic; grants are suppressed during reset.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      tlbpGnt  = 1'b0;
      dataGnt  = 1'b0;
      instGnt  = 1'b0;
      canGrant = !reset && !tlb_write_i && (state_q == IDLE || state_q == RESP);
      if (canGrant) begin
         if (tlbp_req_i) begin
            tlbpGnt = 1'b1;
            owner_d = OWN_TLBP;
         end else if (data_req_i && !(inst_req_i && preferInst)) begin
            dataGnt = 1'b1;
            owner_d = OWN_DATA;
         end else if (inst_req_i) begin
            instGnt = 1'b1;
            owner_d = OWN_INST;
         end
      end
      anyGnt = tlbpGnt | dataGnt | instGnt;
      case (state_q)
         IDLE:    state_d = anyGnt ? SEARCH : IDLE;
         SEARCH:  state_d = tlb_write_i ? SEARCH : RESP;
         RESP:    state_d = anyGnt ? SEARCH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address latch at grant and result capture on a write-free search cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_TLBP;
         vpn2_q    <= '0;
         odd_q     <= 1'b0;
         asid_q    <= '0;
         r_found_o <= 1'b0;
         r_index_o <= '0;
         r_pfn_o   <= '0;
         r_c_o     <= '0;
         r_d_o     <= 1'b0;
         r_v_o     <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (anyGnt) begin
            vpn2_q <= tlbpGnt ? tlbp_vpn2_i : (dataGnt ? data_vpn2_i : inst_vpn2_i);
            odd_q  <= tlbpGnt ? 1'b0 : (dataGnt ? data_odd_i : inst_odd_i);
            asid_q <= cp0_asid_i;
         end
         if (state_q == SEARCH && !tlb_write_i) begin
            r_found_o <= s_found_i;
            r_index_o <= s_index_i;
            r_pfn_o   <= s_pfn_i;
            r_c_o     <= s_c_i;
            r_d_o     <= s_d_i;
            r_v_o     <= s_v_i;
         end
      end
   end

   assign tlbp_gnt_o    = tlbpGnt;
   assign data_gnt_o    = dataGnt;
   assign inst_gnt_o    = instGnt;
   assign tlbp_rvalid_o = !reset && state_q == RESP && owner_q == OWN_TLBP;
   assign data_rvalid_o = !reset && state_q == RESP && owner_q == OWN_DATA;
   assign inst_rvalid_o = !reset && state_q == RESP && owner_q == OWN_INST;
   assign s_vpn2_o      = vpn2_q;
   assign s_odd_page_o  = odd_q;
   assign s_asid_o      = asid_q;

endmodule

// File: doc/tlb_search_arbiter.md
# tlb_search_arbiter

Shares the single TLB search port among three requesters: CP0 TLBP, the data-side translation path and the instruction-side one-entry TLB cache. Each granted lookup gets a registered result on a shared bus, tagged by a per-requester valid strobe. The block sits between the requesters and the TLB array. It keeps lookups from overlapping a TLB write.

## Interface
- TLBNUM, 16, number of TLB entries
- IDXW, 4, index width, log2(TLBNUM)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tlbp_req / data_req / inst_req  in  1 each  lookup requests; each must hold, with its address stable, until its grant
- tlbp_vpn2 / data_vpn2 / inst_vpn2  in  19 each  VA[31:13] to look up
- data_odd / inst_odd  in  1 each  VA[12]; TLBP uses odd=0
- cp0_asid  in  8  EntryHi.ASID, sampled at grant
- tlb_write  in  1  TLBWI/TLBWR writes the array this cycle
- tlbp_gnt / data_gnt / inst_gnt  out  1 each  request accepted (combinational)
- tlbp_rvalid / data_rvalid / inst_rvalid  out  1 each  result valid for one cycle
- s_vpn2 out 19, s_odd_page out 1, s_asid out 8  drive the TLB search port
- s_found in 1, s_index in IDXW, s_pfn in 20, s_c in 3, s_d in 1, s_v in 1  combinational TLB search result
- r_found out 1, r_index out IDXW, r_pfn out 20, r_c out 3, r_d out 1, r_v out 1  registered result bus

## Operation
- FSM states:
  - IDLE=0: no lookup outstanding.
  - SEARCH=1: search port driven from latched address.
  - RESP=2: result presented to owner.
- Grant allowed when state is IDLE or RESP, tlb_write=0, and at least one request is asserted. At most one grant per cycle.
- Priority:
  - tlbp always wins.
  - Between data and inst, the order is set by the Configuration macro.
- On grant:
  - Latch vpn2, odd (tlbp: 0), cp0_asid and a 2-bit owner ID.
  - Next state is SEARCH.
- SEARCH:
  - s_* outputs come from the latch.
  - If tlb_write=0, capture s_found/index/pfn/c/d/v into r_* and go to RESP.
  - If tlb_write=1, discard and stay in SEARCH; the re-search happens the next cycle.
- RESP:
  - Assert the owner's rvalid for exactly one cycle.
  - r_* hold their value until the next capture.
  - If a grant happens in the same cycle, go to SEARCH; otherwise go to IDLE.
- Only one rvalid is ever high. gnt and rvalid of different requesters may coincide in RESP.
- A request deasserted before grant is dropped without side effects.

## Timing
- Grant in cycle N → SEARCH in N+1 → rvalid and r_* valid in N+2.
- Peak throughput: one lookup per 2 cycles.
- Each tlb_write cycle during SEARCH adds one cycle of latency. tlb_write also blocks grants in IDLE/RESP in that cycle.
- Reset values:
  - state=IDLE.
  - All gnt=0 and rvalid=0.
  - r_*=0.
  - Latch, s_vpn2, s_odd_page and s_asid all 0.
  - RR pointer favours data.
- Reset during SEARCH or RESP aborts the lookup. No rvalid follows.
- The requester keeps its req high until it samples gnt. The grant cycle is the request's last cycle.

## Configuration
- TLB_ARB_RR_EN defined:
  - Data and inst alternate round-robin.
  - A 1-bit pointer flips to the other requester after each data or inst grant.
  - Tlbp grants do not move it.
- TLB_ARB_RR_EN undefined: fixed priority tlbp > data > inst, with no pointer register.

## Test plan
- Single inst lookup:
  - Stimulus: inst_req with vpn2=0x12345, odd=1, asid=0x05; TLB returns found=1, index=3, pfn=0x00ABC, v=1, d=0.
  - Response: inst_gnt at N; s_vpn2=0x12345 at N+1; inst_rvalid at N+2 with r_pfn=0x00ABC, r_index=3.
- Three-way contention, all requests held:
  - RR_EN grant order: tlbp, data, inst, at cycles N, N+2, N+4.
  - Without RR_EN: the same order, since each requester drops its req after its grant.
- Persistent data and inst, both re-requesting every RESP, 6 lookups:
  - RR_EN: grants alternate data, inst, data, …
  - Without RR_EN: inst is never granted.
- tlb_write mid-lookup:
  - Stimulus: data granted at N; tlb_write=1 at N+1, with s_pfn changing from 0x11111 to 0x22222 at N+2.
  - Response: data_rvalid at N+3 with r_pfn=0x22222.
- tlb_write in IDLE with inst_req held: no inst_gnt while tlb_write=1; inst_gnt in the first cycle after it clears.
- Reset mid-operation:
  - Stimulus: reset at N+1 after a grant at N.
  - Response: no rvalid at any later cycle; all outputs 0; a fresh request gets gnt in the first cycle after reset deasserts.
